rr_stream_arb: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 41 ++++
 rtl/arb_out_stage.sv | 78 +++++++
 rtl/rr_stream_arb.sv | 142 ++++++++++++++
 tb/tb_rr_stream_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and round-robin search helper for rr_stream_arb
//   arb_state_t   : arbiter FSM states (IDLE, LOCKED)
//   stage_state_t : output stage occupancy (EMPTY, ONE, FULL)
//   rr_pick       : first set bit of mask at or above ptr, wrapping modulo n
package stream_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } stage_state_t;

    // The search runs from the farthest offset down to offset 0 so that the
    // nearest set bit at or after ptr is the last one written and wins.
    // Returns ptr when mask is empty; callers check for an empty mask themselves.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                           input logic [3:0]         ptr,
                                           input int unsigned        n);
        logic [3:0]  pick;
        int unsigned idx;
        pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((32'(i) < n) && mask[idx[3:0]]) begin
                pick = idx[3:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_out_stage.sv
// rtl/arb_out_stage.sv - 2-entry registered skid stage between the arbiter and downstream
//   clk, reset              : clock, synchronous active-high reset
//   push_data/valid/ready   : upstream side; push_ready comes from registered state only
//   pop_data/valid/ready    : downstream side; pop_data/pop_valid are registered
module arb_out_stage
    import stream_arb_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] push_data,
    input  logic         push_valid,
    output logic         push_ready,
    output logic [W-1:0] pop_data,
    output logic         pop_valid,
    input  logic         pop_ready
);

    stage_state_t state, state_nxt;
    logic [W-1:0] head, head_nxt;
    logic [W-1:0] tail, tail_nxt;
    logic         push, pop;

    assign push_ready = (state != FULL);
    assign pop_valid  = (state != EMPTY);
    assign pop_data   = head;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    // head is always the oldest entry; tail is only occupied when FULL.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = push_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = push_data;
                end else if (push) begin
                    state_nxt = FULL;
                    tail_nxt  = push_data;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // push_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

endmodule

// File: rtl/rr_stream_arb.sv
// rtl/rr_stream_arb.sv - N-requester round-robin, packet-locked stream arbiter with registered output
//   clk, reset                 : clock, synchronous active-high reset
//   cfg_mask                   : per-requester eligibility for a new grant
//   i_valid/i_ready/i_data/i_last : per-requester beat interface, i_data packed DATA_W per requester
//   o_data/o_last/o_src/o_valid/o_ready : merged stream out of the skid stage
//   busy                       : high while a multi-beat packet holds the grant
module rr_stream_arb
    import stream_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        cfg_mask,
    input  logic [N_REQ-1:0]        i_valid,
    output logic [N_REQ-1:0]        i_ready,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    input  logic [N_REQ-1:0]        i_last,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_last,
    output logic [SRC_W-1:0]        o_src,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    busy
);

    localparam int ENTRY_W = SRC_W + 1 + DATA_W;

    arb_state_t         state, state_nxt;
    logic [SRC_W-1:0]   gnt, gnt_nxt;
    logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;

    logic [N_REQ-1:0]   eligible;
    logic [MAX_REQ-1:0] mask_ext;
    logic [3:0]         ptr_ext;
    logic [3:0]         pick_ext;
    logic               unused_pick_hi;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W-1:0]   sel_inc;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic               push;
    logic               stage_ready;
    logic [ENTRY_W-1:0] stage_in;
    logic [ENTRY_W-1:0] stage_out;

    always_comb begin
        eligible                = i_valid & cfg_mask;
        mask_ext                = '0;
        mask_ext[N_REQ-1:0]     = eligible;
        ptr_ext                 = '0;
        ptr_ext[SRC_W-1:0]      = rr_ptr;
        pick_ext                = rr_pick(mask_ext, ptr_ext, N_REQ);
    end

    assign pick           = pick_ext[SRC_W-1:0];
    assign unused_pick_hi = ^pick_ext;

    // In LOCKED the mask is bypassed: the held requester always gets to finish.
    assign sel     = (state == LOCKED) ? gnt : pick;
    assign sel_inc = (32'(sel) == 32'(N_REQ - 1)) ? '0 : sel + SRC_W'(1);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        i_ready  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == SRC_W'(k)) begin
                sel_data = i_data[k*DATA_W +: DATA_W];
                sel_last = i_last[k];
                if (!reset && ((state == LOCKED) || (|eligible))) begin
                    i_ready[k] = stage_ready;
                end
            end
        end
    end

    assign push     = |(i_valid & i_ready);
    assign stage_in = {sel, sel_last, sel_data};

    // The grant decision made this cycle only takes effect next cycle, so a
    // last-beat accept never regrants in the same cycle.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (push) begin
                    if (sel_last) begin
                        rr_ptr_nxt = sel_inc;
                    end else begin
                        state_nxt = LOCKED;
                        gnt_nxt   = pick;
                    end
                end
            end
            LOCKED: begin
                if (push && sel_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = sel_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign busy = (state == LOCKED);

    arb_out_stage #(
        .W(ENTRY_W)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .push_data  (stage_in),
        .push_valid (push),
        .push_ready (stage_ready),
        .pop_data   (stage_out),
        .pop_valid  (o_valid),
        .pop_ready  (o_ready)
    );

    assign {o_src, o_last, o_data} = stage_out;

endmodule

// File: tb/tb_rr_stream_arb.sv
// tb/tb_rr_stream_arb.sv - directed self-checking bench for rr_stream_arb
module tb_rr_stream_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic          last;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cfg_mask;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_ready;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_last;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [SW-1:0]   o_src;
    logic            o_valid;
    logic            o_ready;
    logic            busy;

    logic [DW:0]     sq [N][$];
    beat_t           out_q[$];
    logic [N-1:0]    acc;
    int unsigned     cyc_cnt = 0;
    int              n_cmp = 0;
    int              n_mis = 0;

    always #5 clk = ~clk;

    rr_stream_arb #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_mask (cfg_mask),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_src    (o_src),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .busy     (busy)
    );

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (sq[k].size() > 0) begin
                i_valid[k]         = 1'b1;
                i_data[k*DW +: DW] = sq[k][0][DW-1:0];
                i_last[k]          = sq[k][0][DW];
            end else begin
                i_valid[k]         = 1'b0;
                i_data[k*DW +: DW] = '0;
                i_last[k]          = 1'b0;
            end
        end
    endtask

    task automatic sample();
        beat_t b;
        @(negedge clk);
        cyc_cnt++;
        acc = reset ? '0 : (i_valid & i_ready);
        if (!reset && o_valid && o_ready) begin
            b.src  = o_src;
            b.last = o_last;
            b.data = o_data;
            b.cyc  = cyc_cnt;
            out_q.push_back(b);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) void'(sq[k].pop_front());
        end
        refresh();
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) begin
            if (sq[k].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int max_cyc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            sample();
            done = (o_valid == 1'b0) && all_empty();
            advance();
            n++;
            if (!done && n >= max_cyc) begin
                n_cmp++; n_mis++;
                $display("FAIL %s_drain: still busy after %0d cycles, want drained", name, n);
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        o_ready  = 1'b1;
        cfg_mask = 4'hF;
        for (int k = 0; k < N; k++) sq[k].push_back({1'b1, 32'h100 + 32'(k)});
        refresh();
        for (int c = 0; c < 3; c++) begin
            sample();
            n_cmp++;
            if (i_ready !== 4'b0000) begin n_mis++; $display("FAIL rst_i_ready[%0d]: got %b want 0000", c, i_ready); end
            n_cmp++;
            if (o_valid !== 1'b0) begin n_mis++; $display("FAIL rst_o_valid[%0d]: got %b want 0", c, o_valid); end
            n_cmp++;
            if ({o_data, o_last, o_src, busy} !== '0) begin
                n_mis++;
                $display("FAIL rst_outs[%0d]: got data=%h last=%b src=%0d busy=%b want all 0", c, o_data, o_last, o_src, busy);
            end
            advance();
        end
        reset = 1'b0;
        sample();
        n_cmp++;
        if (i_ready !== 4'b0001) begin n_mis++; $display("FAIL rst_first_grant: got %b want 0001", i_ready); end
        advance();
        sample();
        n_cmp++;
        if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 32'h100) begin
            n_mis++;
            $display("FAIL rst_first_out: got valid=%b src=%0d data=%h want 1/0/00000100", o_valid, o_src, o_data);
        end
        advance();
        drain("reset", 40);
        n_cmp++;
        if (out_q.size() != 4) begin
            n_mis++; $display("FAIL rst_count: got %0d want 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (out_q[i].src !== SW'(i) || out_q[i].data !== 32'h100 + 32'(i) || out_q[i].last !== 1'b1) begin
                    n_mis++;
                    $display("FAIL rst_beat[%0d]: got src=%0d data=%h want src=%0d data=%h", i, out_q[i].src, out_q[i].data, i, 32'h100 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        out_q.delete();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < N; k++) sq[k].push_back({1'b1, 32'h200 + 32'(16 * k + j)});
        refresh();
        drain("rr", 40);
        n_cmp++;
        if (out_q.size() != 8) begin
            n_mis++; $display("FAIL rr_count: got %0d want 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (out_q[i].src !== SW'(i % 4) || out_q[i].data !== 32'h200 + 32'(16 * (i % 4) + i / 4)) begin
                    n_mis++;
                    $display("FAIL rr_beat[%0d]: got src=%0d data=%h want src=%0d data=%h",
                             i, out_q[i].src, out_q[i].data, i % 4, 32'h200 + 32'(16 * (i % 4) + i / 4));
                end
                if (i > 0) begin
                    n_cmp++;
                    if (out_q[i].cyc !== out_q[i-1].cyc + 1) begin
                        n_mis++;
                        $display("FAIL rr_rate[%0d]: got cycle gap %0d want 1", i, out_q[i].cyc - out_q[i-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [31:0]   exp_data [5];
        logic [SW-1:0] exp_src  [5];
        logic          exp_last [5];
        exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1};
        exp_src  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_q.delete();
        sq[2].push_back({1'b0, 32'hA0});
        sq[2].push_back({1'b0, 32'hA1});
        sq[2].push_back({1'b1, 32'hA2});
        refresh();
        sample();
        advance();
        sq[1].push_back({1'b0, 32'hB0});
        sq[1].push_back({1'b1, 32'hB1});
        refresh();
        sample();
        n_cmp++;
        if (busy !== 1'b1 || i_ready !== 4'b0100) begin
            n_mis++; $display("FAIL lock_hold: got busy=%b i_ready=%b want 1/0100", busy, i_ready);
        end
        advance();
        drain("lock", 40);
        n_cmp++;
        if (out_q.size() != 5) begin
            n_mis++; $display("FAIL lock_count: got %0d want 5", out_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (out_q[i].src !== exp_src[i] || out_q[i].data !== exp_data[i] || out_q[i].last !== exp_last[i]) begin
                    n_mis++;
                    $display("FAIL lock_beat[%0d]: got src=%0d data=%h last=%b want src=%0d data=%h last=%b",
                             i, out_q[i].src, out_q[i].data, out_q[i].last, exp_src[i], exp_data[i], exp_last[i]);
                end
            end
            n_cmp++;
            if (out_q[3].cyc !== out_q[2].cyc + 1) begin
                n_mis++; $display("FAIL lock_follow: got gap %0d want 1", out_q[3].cyc - out_q[2].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        out_q.delete();
        o_ready = 1'b0;
        for (int j = 0; j < 4; j++) sq[0].push_back({(j == 3), 32'hC0 + 32'(j)});
        refresh();
        for (int c = 1; c <= 5; c++) begin
            sample();
            if (c == 1) begin
                n_cmp++;
                if (i_ready !== 4'b0001) begin n_mis++; $display("FAIL bp_wrap_grant: got %b want 0001", i_ready); end
            end
            if (c == 3 || c == 5) begin
                n_cmp++;
                if (i_ready !== 4'b0000 || o_valid !== 1'b1 || o_data !== 32'hC0 || busy !== 1'b1) begin
                    n_mis++;
                    $display("FAIL bp_full[%0d]: got i_ready=%b valid=%b data=%h busy=%b want 0000/1/000000c0/1",
                             c, i_ready, o_valid, o_data, busy);
                end
            end
            advance();
        end
        o_ready = 1'b1;
        drain("bp", 40);
        n_cmp++;
        if (out_q.size() != 4) begin
            n_mis++; $display("FAIL bp_count: got %0d want 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (out_q[i].src !== 2'd0 || out_q[i].data !== 32'hC0 + 32'(i) || out_q[i].last !== (i == 3)) begin
                    n_mis++;
                    $display("FAIL bp_beat[%0d]: got src=%0d data=%h last=%b want src=0 data=%h last=%b",
                             i, out_q[i].src, out_q[i].data, out_q[i].last, 32'hC0 + 32'(i), (i == 3));
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0]   exp_data [7];
        logic [SW-1:0] exp_src  [7];
        exp_data = '{32'hD0, 32'hD1, 32'hD2, 32'hE0, 32'hF0, 32'hE1, 32'hF1};
        exp_src  = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
        out_q.delete();
        for (int j = 0; j < 3; j++) sq[3].push_back({(j == 2), 32'hD0 + 32'(j)});
        refresh();
        sample();
        n_cmp++;
        if (i_ready !== 4'b1000) begin n_mis++; $display("FAIL mask_grant3: got %b want 1000", i_ready); end
        advance();
        cfg_mask = 4'b0111;
        sq[0].push_back({1'b1, 32'hE0});
        sq[0].push_back({1'b1, 32'hE1});
        sq[1].push_back({1'b1, 32'hF0});
        sq[1].push_back({1'b1, 32'hF1});
        sq[3].push_back({1'b1, 32'hEE});
        refresh();
        for (int c = 0; c < 14; c++) begin
            sample();
            advance();
        end
        sample();
        n_cmp++;
        if (i_ready !== 4'b0000 || o_valid !== 1'b0) begin
            n_mis++; $display("FAIL mask_no_regrant: got i_ready=%b valid=%b want 0000/0", i_ready, o_valid);
        end
        advance();
        n_cmp++;
        if (out_q.size() != 7) begin
            n_mis++; $display("FAIL mask_count: got %0d want 7", out_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (out_q[i].src !== exp_src[i] || out_q[i].data !== exp_data[i]) begin
                    n_mis++;
                    $display("FAIL mask_beat[%0d]: got src=%0d data=%h want src=%0d data=%h",
                             i, out_q[i].src, out_q[i].data, exp_src[i], exp_data[i]);
                end
            end
        end
        sq[3].delete();
        cfg_mask = 4'hF;
        refresh();
    endtask

    task automatic test_reset_mid();
        out_q.delete();
        o_ready = 1'b0;
        for (int j = 0; j < 4; j++) sq[1].push_back({(j == 3), 32'h90 + 32'(j)});
        refresh();
        sample();
        n_cmp++;
        if (i_ready !== 4'b0010) begin n_mis++; $display("FAIL rmid_grant: got %b want 0010", i_ready); end
        advance();
        sample();
        n_cmp++;
        if (busy !== 1'b1 || o_valid !== 1'b1) begin
            n_mis++; $display("FAIL rmid_locked: got busy=%b valid=%b want 1/1", busy, o_valid);
        end
        advance();
        reset   = 1'b1;
        o_ready = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        sq[1].delete();
        refresh();
        sample();
        n_cmp++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || i_ready !== 4'b0000) begin
            n_mis++; $display("FAIL rmid_after: got valid=%b busy=%b i_ready=%b want 0/0/0000", o_valid, busy, i_ready);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            sample();
            advance();
        end
        n_cmp++;
        if (out_q.size() != 0) begin n_mis++; $display("FAIL rmid_flushed: got %0d beats want 0", out_q.size()); end
        sq[3].push_back({1'b1, 32'h33});
        sq[0].push_back({1'b1, 32'h30});
        refresh();
        sample();
        n_cmp++;
        if (i_ready !== 4'b0001) begin n_mis++; $display("FAIL rmid_ptr0: got %b want 0001", i_ready); end
        advance();
        drain("rmid", 40);
        n_cmp++;
        if (out_q.size() != 2 || out_q[0].src !== 2'd0 || out_q[1].src !== 2'd3) begin
            n_mis++; $display("FAIL rmid_order: got %0d beats first src=%0d want 2 beats src 0 then 3",
                              out_q.size(), (out_q.size() > 0) ? out_q[0].src : 2'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        cfg_mask = '0;
        i_valid  = '0;
        i_data   = '0;
        i_last   = '0;
        o_ready  = 1'b0;
        acc      = '0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_mask();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
